// File: rtl/sample_rate_gen.sv
`default_nettype none
// ============================================================================
// Module      : sample_rate_gen
// Description : PLL-lock-gated multi-channel sample-enable strobe generator
//               with shadowed, wrap-aligned divider updates and phase sync.
// Revision    : 1.0 - initial release
// ============================================================================
module sample_rate_gen #(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 16,
    parameter int LOCK_WAIT = 1024
) (
    input  logic              refclk,
    input  logic              rst,
    input  logic              locked,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              cfg_valid,
    input  logic [2:0]        cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    output logic              cfg_ready,
    input  logic              phase_sync,
    input  logic              lock_lost_clr,
    output logic [NUM_CH-1:0] sample_en,
    output logic              ready,
    output logic              lock_lost
);

    localparam int SET_W = $clog2(LOCK_WAIT);
    localparam logic [SET_W-1:0] c_SETTLE_LAST = SET_W'(LOCK_WAIT - 1);

    localparam logic [1:0] c_WAIT_LOCK = 2'd0;
    localparam logic [1:0] c_SETTLE    = 2'd1;
    localparam logic [1:0] c_RUN       = 2'd2;
    localparam logic [1:0] c_LOST      = 2'd3;

    logic             r_lk_meta;
    logic             r_lk_s;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [SET_W-1:0] r_settle_cnt;
    logic             r_ready;
    logic             r_lock_lost;
    logic             w_run;
    logic             w_lost_set;

    assign cfg_ready  = 1'b1;
    assign w_run      = (r_state == c_RUN);
    assign w_lost_set = w_run && !r_lk_s;
    assign ready      = r_ready;
    assign lock_lost  = r_lock_lost;

    // locked comes from the PLL domain, so only the resynchronised copy is used
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk_s    <= 1'b0;
        end else begin
            r_lk_meta <= locked;
            r_lk_s    <= r_lk_meta;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_WAIT_LOCK: if (r_lk_s) w_state_nxt = c_SETTLE;
            c_SETTLE: begin
                if (!r_lk_s)
                    w_state_nxt = c_WAIT_LOCK;
                else if (r_settle_cnt == c_SETTLE_LAST)
                    w_state_nxt = c_RUN;
            end
            c_RUN:       if (!r_lk_s) w_state_nxt = c_LOST;
            c_LOST:      w_state_nxt = c_WAIT_LOCK;
            default:     w_state_nxt = c_WAIT_LOCK;
        endcase
    end

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state      <= c_WAIT_LOCK;
            r_settle_cnt <= '0;
            r_ready      <= 1'b0;
            r_lock_lost  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= (w_state_nxt == c_RUN);
            if (r_state == c_SETTLE && r_lk_s)
                r_settle_cnt <= r_settle_cnt + 1'b1;
            else
                r_settle_cnt <= '0;
            if (w_lost_set)
                r_lock_lost <= 1'b1;
            else if (lock_lost_clr)
                r_lock_lost <= 1'b0;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic [DIV_W-1:0] r_div;
        logic [DIV_W-1:0] r_sh;
        logic [DIV_W-1:0] r_cnt;
        logic             r_pend;
        logic             w_wr;
        logic             w_zero;
        logic             w_reload;

        // channel indices at or above NUM_CH never match, so such writes drop
        assign w_wr     = cfg_valid && cfg_ready && (cfg_ch == 3'(i));
        assign w_zero   = (r_cnt == '0);
        assign w_reload = w_run && w_zero && !phase_sync;

        assign sample_en[i] = w_run && ch_en[i] && w_zero;

        always_ff @(posedge refclk or posedge rst) begin
            if (rst) begin
                r_div  <= '0;
                r_sh   <= '0;
                r_cnt  <= '0;
                r_pend <= 1'b0;
            end else begin
                if (!w_run || phase_sync)
                    r_cnt <= '0;
                else if (w_zero)
                    r_cnt <= r_pend ? r_sh : r_div;
                else
                    r_cnt <= r_cnt - 1'b1;

                // the reload consumes the old shadow; a write on the same edge re-arms it
                if (w_reload && r_pend)
                    r_div <= r_sh;
                else if (w_wr && !w_run)
                    r_div <= cfg_div;

                if (w_wr && w_run)
                    r_sh <= cfg_div;

                if (w_wr)
                    r_pend <= w_run;
                else if (w_reload)
                    r_pend <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sample_rate_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_rate_gen
// Description : Self-checking bench for sample_rate_gen against a
//               schedule-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_rate_gen;

    localparam int NUM_CH    = 2;
    localparam int DIV_W     = 4;
    localparam int LOCK_WAIT = 8;

    logic              refclk        = 1'b0;
    logic              rst           = 1'b1;
    logic              locked        = 1'b0;
    logic [NUM_CH-1:0] ch_en         = '0;
    logic              cfg_valid     = 1'b0;
    logic [2:0]        cfg_ch        = '0;
    logic [DIV_W-1:0]  cfg_div       = '0;
    logic              phase_sync    = 1'b0;
    logic              lock_lost_clr = 1'b0;
    logic              cfg_ready;
    logic [NUM_CH-1:0] sample_en;
    logic              ready;
    logic              lock_lost;

    int checks = 0;
    int errors = 0;

    // Reference model: absolute cycle time t, lock streak, and per-channel
    // scheduled strobe time with active/pending divider values.
    int t = 0;
    bit m_meta, m_lks, m_run, m_lost, m_flag;
    int m_streak;
    int m_n    [NUM_CH];
    int m_pn   [NUM_CH];
    bit m_hasp [NUM_CH];
    int m_next [NUM_CH];

    sample_rate_gen #(
        .NUM_CH    (NUM_CH),
        .DIV_W     (DIV_W),
        .LOCK_WAIT (LOCK_WAIT)
    ) dut (
        .refclk        (refclk),
        .rst           (rst),
        .locked        (locked),
        .ch_en         (ch_en),
        .cfg_valid     (cfg_valid),
        .cfg_ch        (cfg_ch),
        .cfg_div       (cfg_div),
        .cfg_ready     (cfg_ready),
        .phase_sync    (phase_sync),
        .lock_lost_clr (lock_lost_clr),
        .sample_en     (sample_en),
        .ready         (ready),
        .lock_lost     (lock_lost)
    );

    always #5 refclk = ~refclk;

    initial begin
        #500000;
        $display("FAIL watchdog t=%0d", t);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s t=%0d got %0h expected %0h", tag, t, got, exp);
        end
    endtask

    task automatic model_reset();
        m_meta = 0; m_lks = 0; m_run = 0; m_lost = 0; m_flag = 0; m_streak = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_n[i] = 0; m_pn[i] = 0; m_hasp[i] = 0; m_next[i] = 0;
        end
    endtask

    task automatic model_edge();
        bit was_run;
        bit set_flag;
        if (rst) begin
            model_reset();
            t++;
            return;
        end
        was_run = m_run;
        for (int i = 0; i < NUM_CH; i++) begin
            bit wr;
            wr = cfg_valid && (int'(cfg_ch) == i);
            if (was_run) begin
                if (phase_sync)
                    m_next[i] = t + 1;
                else if (t == m_next[i]) begin
                    if (m_hasp[i]) begin
                        m_n[i]    = m_pn[i];
                        m_hasp[i] = 0;
                    end
                    m_next[i] = t + 1 + m_n[i];
                end
                if (wr) begin
                    m_pn[i]   = int'(cfg_div);
                    m_hasp[i] = 1;
                end
            end else if (wr) begin
                m_n[i]    = int'(cfg_div);
                m_hasp[i] = 0;
            end
        end
        set_flag = 0;
        if (m_lost) begin
            m_lost   = 0;
            m_streak = 0;
        end else if (m_run) begin
            if (!m_lks) begin
                m_run    = 0;
                m_lost   = 1;
                set_flag = 1;
            end
        end else if (!m_lks) begin
            m_streak = 0;
        end else begin
            m_streak++;
            if (m_streak == LOCK_WAIT + 1) begin
                m_run    = 1;
                m_streak = 0;
                for (int i = 0; i < NUM_CH; i++) m_next[i] = t + 1;
            end
        end
        if (set_flag)
            m_flag = 1;
        else if (lock_lost_clr)
            m_flag = 0;
        m_lks = m_meta;
        m_meta = locked;
        t++;
    endtask

    task automatic cycle();
        logic [NUM_CH-1:0] e;
        #1;
        for (int i = 0; i < NUM_CH; i++)
            e[i] = m_run && ch_en[i] && (t == m_next[i]);
        chk("sample_en", 32'(sample_en), 32'(e));
        chk("ready", 32'(ready), 32'(m_run));
        chk("lock_lost", 32'(lock_lost), 32'(m_flag));
        chk("cfg_ready", 32'(cfg_ready), 32'd1);
        @(posedge refclk);
        model_edge();
        #1;
    endtask

    task automatic write_cfg(input int ch, input int n);
        cfg_valid = 1'b1;
        cfg_ch    = 3'(ch);
        cfg_div   = DIV_W'(n);
        cycle();
        cfg_valid = 1'b0;
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic count_until_ready(output int n);
        n = 0;
        while (ready !== 1'b1 && n < 60) begin
            cycle();
            n++;
        end
    endtask

    task automatic rand_phase(input int n, input bit toggle_lock);
        for (int k = 0; k < n; k++) begin
            cfg_valid     = ($urandom_range(0, 3) == 0);
            cfg_ch        = 3'($urandom_range(0, 7));
            cfg_div       = DIV_W'($urandom);
            ch_en         = NUM_CH'($urandom);
            phase_sync    = ($urandom_range(0, 19) == 0);
            lock_lost_clr = ($urandom_range(0, 9) == 0);
            if (toggle_lock && $urandom_range(0, 29) == 0) locked = ~locked;
            cycle();
        end
        cfg_valid = 0; phase_sync = 0; lock_lost_clr = 0;
    endtask

    initial begin
        int n;
        int strobes;
        model_reset();
        @(posedge refclk); model_edge();
        @(posedge refclk); model_edge();
        #1;
        rst = 1'b0;
        run(3);

        // dividers loaded directly before lock
        write_cfg(0, 3);
        write_cfg(1, 4);
        ch_en = '1;
        run(2);

        locked = 1'b1;
        count_until_ready(n);
        chk("ready_latency", 32'(n), 32'd11);
        chk("first_strobe", 32'(sample_en[0]), 32'd1);

        strobes = 0;
        for (int k = 0; k < 16; k++) begin
            strobes += int'(sample_en[0]);
            cycle();
        end
        chk("ch0_rate_n3", 32'(strobes), 32'd4);

        // period change two cycles after a strobe
        n = 0;
        while (sample_en[0] !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("strobe_found", 32'(n < 20), 32'd1);
        run(2);
        write_cfg(0, 1);
        run(12);

        // pending shadows applied at the phase-sync realignment
        write_cfg(0, 2);
        write_cfg(1, 4);
        run(3);
        phase_sync = 1'b1;
        cycle();
        phase_sync = 1'b0;
        chk("sync_both", 32'(sample_en), 32'(2'b11));
        run(20);

        // out-of-range channel write has no effect
        write_cfg(5, 0);
        run(12);

        // boundary dividers
        write_cfg(0, 0);
        write_cfg(1, 15);
        run(40);

        rand_phase(300, 1'b0);

        // lock loss and sticky flag
        locked = 1'b0;
        n = 0;
        while (lock_lost !== 1'b1 && n < 20) begin cycle(); n++; end
        chk("lost_latency", 32'(n), 32'd3);
        chk("lost_ready", 32'(ready), 32'd0);
        run(2);
        lock_lost_clr = 1'b1;
        cycle();
        lock_lost_clr = 1'b0;
        chk("lost_clr", 32'(lock_lost), 32'd0);
        run(3);
        locked = 1'b1;
        count_until_ready(n);
        chk("relock_latency", 32'(n), 32'd11);

        rand_phase(300, 1'b1);

        locked = 1'b0;
        run(5);
        locked = 1'b1;
        count_until_ready(n);
        chk("final_lock_latency", 32'(n), 32'd11);

        // asynchronous reset while strobing every cycle
        ch_en = '1;
        write_cfg(0, 0);
        write_cfg(1, 0);
        run(4);
        chk("pre_rst_strobes", 32'(sample_en), 32'(2'b11));
        rst = 1'b1;
        #1;
        chk("rst_sample_en", 32'(sample_en), 32'd0);
        chk("rst_ready", 32'(ready), 32'd0);
        chk("rst_lock_lost", 32'(lock_lost), 32'd0);
        @(posedge refclk); model_edge();
        #1;
        rst = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sample_rate_gen.md
SAMPLE_RATE_GEN -- requirements
Module: sample_rate_gen

Interface
- REQ-001 SHALL have parameter NUM_CH, default 2; number of independent sample-enable channels, 1..8.
- REQ-002 SHALL have parameter DIV_W, default 16; divider width per channel.
- REQ-003 SHALL have parameter LOCK_WAIT, default 1024; cycles of continuous lock required before running, at least 2.
- REQ-004 SHALL have port refclk, input, 1: the single clock (capture PLL output); all logic is on its rising edge.
- REQ-005 SHALL have port rst, input, 1: reset; asynchronous, active-high.
- REQ-006 SHALL have port locked, input, 1: PLL lock, asynchronous to refclk.
- REQ-007 SHALL have port ch_en, input, NUM_CH: per-channel strobe enable.
- REQ-008 SHALL have port cfg_valid, input, 1: divider write request.
- REQ-009 SHALL have port cfg_ch, input, 3: target channel index.
- REQ-010 SHALL have port cfg_div, input, DIV_W: divider value N; strobe period is N+1 cycles.
- REQ-011 SHALL have port cfg_ready, output, 1: write accept.
- REQ-012 SHALL have port phase_sync, input, 1: realign all channel counters.
- REQ-013 SHALL have port lock_lost_clr, input, 1: clear the sticky flag.
- REQ-014 SHALL have port sample_en, output, NUM_CH: one-cycle sample strobes.
- REQ-015 SHALL have port ready, output, 1: high only in RUN.
- REQ-016 SHALL have port lock_lost, output, 1: sticky lock-loss flag.

Function
- REQ-017 SHALL pass locked through a 2-flop synchronizer (lk_s); all lock decisions use lk_s.
- REQ-018 SHALL implement FSM WAIT_LOCK, SETTLE, RUN, LOST.
- REQ-019 WAIT_LOCK: lk_s=1 -> SETTLE with settle counter cleared.
- REQ-020 SETTLE: counter increments each cycle lk_s=1; lk_s=0 -> WAIT_LOCK; counter=LOCK_WAIT-1 -> RUN.
- REQ-021 RUN: lk_s=0 -> LOST, lock_lost set the same edge.
- REQ-022 LOST: strobes off; unconditionally -> WAIT_LOCK after one cycle.
- REQ-023 ready SHALL be registered and equal 1 only while the state is RUN.
- REQ-024 Each channel SHALL hold active divider div[i], shadow sh[i], pending flag pend[i], and down-counter cnt[i].
- REQ-025 sample_en[i] SHALL equal (state==RUN) & ch_en[i] & (cnt[i]==0), combinational from registers.
- REQ-026 Outside RUN, cnt[i] SHALL be held at 0, so the first strobe occurs on the first RUN cycle.
- REQ-027 In RUN, when cnt[i]==0 the counter SHALL reload with the divider; otherwise it decrements. The reload value is sh[i] if pend[i], else div[i].
- REQ-028 On a reload while pend[i] is set, div[i] SHALL take sh[i] and pend[i] SHALL clear, giving a glitch-free period change at the wrap.
- REQ-029 cfg_ready SHALL be constant 1; a write is accepted when cfg_valid=1.
- REQ-030 An accepted write with cfg_ch<NUM_CH SHALL load sh and set pend in RUN, and SHALL load div directly outside RUN.
- REQ-031 An accepted write with cfg_ch>=NUM_CH SHALL be ignored.
- REQ-032 A write landing on the same edge as that channel's reload SHALL go to sh/pend; the reload uses the old shadow state.
- REQ-033 phase_sync=1 in RUN SHALL force all cnt[i] to 0 next cycle, so all enabled channels strobe together; any pending shadows are applied on that reload.
- REQ-034 phase_sync SHALL have priority over a normal reload.
- REQ-035 ch_en SHALL gate strobes only; counters run regardless of ch_en.
- REQ-036 lock_lost SHALL clear on lock_lost_clr=1; a simultaneous set SHALL win.
- REQ-037 Divider N=0 SHALL strobe every RUN cycle; N=2^DIV_W-1 SHALL give period 2^DIV_W.

Reset
- REQ-038 rst=1 SHALL asynchronously force: state WAIT_LOCK, synchronizer 0, all cnt/div/sh/pend 0, sample_en 0, ready 0, lock_lost 0.
- REQ-039 Reset asserted mid-RUN SHALL drop sample_en and ready without waiting for a clock edge.

Verification
- REQ-040 LOCK_WAIT=8, locked rising at cycle 0 -> ready=1 at cycle 11 (2 sync + 8 settle + 1), first sample_en the same cycle.
- REQ-041 cfg_div=3 on ch0 before lock, ch_en=1 -> sample_en[0] high every 4th cycle in RUN.
- REQ-042 In RUN, ch0 at N=3, write N=1 two cycles after a strobe -> one more period of 4, then period 2, with no runt strobe.
- REQ-043 ch0 N=2, ch1 N=4, pulse phase_sync -> both strobe on the next cycle, then at periods 3 and 5.
- REQ-044 locked drops in RUN -> ready=0 and lock_lost=1 three cycles later; lock_lost_clr clears the flag; relock follows REQ-040.
- REQ-045 cfg_ch=5 with NUM_CH=2 -> no divider change; rst pulse mid-RUN -> all outputs 0 immediately.
